// File: rtl/fpnew_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpnew_pkg
// Description : Shared types and helpers for the iterative div/sqrt engine.
// Revision    : 1.0 - initial release
// ============================================================================
package fpnew_pkg;

  // Operation selected when a start is accepted.
  typedef enum logic {
    DS_DIV  = 1'b0,
    DS_SQRT = 1'b1
  } divsqrt_op_e;

  // Engine sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_FINISH = 2'd2
  } divsqrt_state_e;

  // Cycles spent in BUSY: enough radix-2 steps to cover MantWidth+2 result bits.
  function automatic int unsigned divsqrt_num_iter(input int unsigned mant_width,
                                                   input int unsigned bits_per_cycle);
    return (mant_width + 2 + bits_per_cycle - 1) / bits_per_cycle;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpnew_divsqrt_iter_step.sv
`default_nettype none
// ============================================================================
// Module      : fpnew_divsqrt_iter_step
// Description : One combinational radix-2 restoring step, shared by divide
//               and square root. Produces the updated partial remainder and
//               the result bit retired by this step.
// Revision    : 1.0 - initial release
// ============================================================================
module fpnew_divsqrt_iter_step
  import fpnew_pkg::*;
#(
  parameter int unsigned RemWidth  = 28,
  parameter int unsigned QuotWidth = 26
) (
  input  divsqrt_op_e         op_i,
  input  logic [RemWidth-1:0] rem_i,
  input  logic [QuotWidth-1:0] quot_i,
  input  logic [RemWidth-1:0] divisor_i,
  input  logic [1:0]          rad_pair_i,
  output logic [RemWidth-1:0] rem_o,
  output logic                bit_o
);

  logic [RemWidth-1:0] w_div_diff;
  logic [RemWidth-1:0] w_sqrt_rem4;
  logic [RemWidth-1:0] w_sqrt_trial;
  logic [RemWidth-1:0] w_sqrt_diff;
  logic                w_div_ge;
  logic                w_sqrt_ge;

  // Divide compares before shifting; sqrt shifts in the next radicand pair
  // first and compares against the trial value 4*root+1.
  always_comb begin
    w_div_ge     = rem_i >= divisor_i;
    w_div_diff   = rem_i - divisor_i;
    w_sqrt_rem4  = {rem_i[RemWidth-3:0], rad_pair_i};
    w_sqrt_trial = RemWidth'({quot_i, 2'b01});
    w_sqrt_ge    = w_sqrt_rem4 >= w_sqrt_trial;
    w_sqrt_diff  = w_sqrt_rem4 - w_sqrt_trial;
    if (op_i == DS_DIV) begin
      bit_o = w_div_ge;
      rem_o = (w_div_ge ? w_div_diff : rem_i) << 1;
    end else begin
      bit_o = w_sqrt_ge;
      rem_o = w_sqrt_ge ? w_sqrt_diff : w_sqrt_rem4;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpnew_divsqrt_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : fpnew_divsqrt_iter_core
// Description : Iterative significand divide / square-root engine answering
//               the start/ready/done/kill handshake of the divsqrt wrapper.
//               When NUM_ITER*BitsPerCycle exceeds MantWidth+2, the surplus
//               low bits are computed and folded into sticky.
// Revision    : 1.0 - initial release
// ============================================================================
module fpnew_divsqrt_iter_core
  import fpnew_pkg::*;
#(
  parameter int unsigned MantWidth    = 53,
  parameter int unsigned BitsPerCycle = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 div_start_i,
  input  logic                 sqrt_start_i,
  input  logic [MantWidth-1:0] operand_a_i,
  input  logic [MantWidth-1:0] operand_b_i,
  input  logic                 exp_odd_i,
  input  logic                 kill_i,
  output logic                 ready_o,
  output logic                 done_o,
  output logic [MantWidth+1:0] result_o,
  output logic                 sticky_o
);

  localparam int unsigned NUM_ITER = divsqrt_num_iter(MantWidth, BitsPerCycle);
  localparam int unsigned RES_W    = MantWidth + 2;
  localparam int unsigned QUOT_W   = NUM_ITER * BitsPerCycle;
  localparam int unsigned EXTRA    = QUOT_W - RES_W;
  localparam int unsigned REM_W    = QUOT_W + 2;
  // Radicand held left-aligned on an even width so pairs come off the top.
  localparam int unsigned RAD_W    = MantWidth + 1 + ((MantWidth + 1) % 2);
  localparam int unsigned RAD_PAD  = RAD_W - (MantWidth + 1);
  localparam int unsigned CNT_W    = $clog2(NUM_ITER + 1);
  localparam logic [QUOT_W-1:0] LOW_MASK = (QUOT_W'(1) << EXTRA) - QUOT_W'(1);

  divsqrt_state_e       state_q;
  divsqrt_op_e          op_q;
  logic                 ready_q;
  logic                 done_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [REM_W-1:0]     rem_q;
  logic [QUOT_W-1:0]    quot_q;
  logic [MantWidth-1:0] divisor_q;
  logic [RAD_W-1:0]     rad_q;
  logic [RES_W-1:0]     result_q;
  logic                 sticky_q;

  logic                 w_start;
  divsqrt_op_e          w_start_op;
  logic [MantWidth:0]   w_rad_x;
  logic [RAD_W-1:0]     w_rad_init;
  logic [REM_W-1:0]     w_divisor;
  logic [REM_W-1:0]     w_rem  [BitsPerCycle+1];
  logic [QUOT_W-1:0]    w_quot [BitsPerCycle+1];
  logic                 w_sticky;

  assign w_start    = div_start_i | sqrt_start_i;
  assign w_start_op = div_start_i ? DS_DIV : DS_SQRT;
  assign w_rad_x    = exp_odd_i ? {operand_a_i, 1'b0} : {1'b0, operand_a_i};
  assign w_rad_init = RAD_W'(w_rad_x) << RAD_PAD;
  assign w_divisor  = REM_W'(divisor_q);
  assign w_rem[0]   = rem_q;
  assign w_quot[0]  = quot_q;

  generate
    for (genvar gi = 0; gi < BitsPerCycle; gi++) begin : g_step
      logic w_bit;
      fpnew_divsqrt_iter_step #(
        .RemWidth  (REM_W),
        .QuotWidth (QUOT_W)
      ) u_step (
        .op_i       (op_q),
        .rem_i      (w_rem[gi]),
        .quot_i     (w_quot[gi]),
        .divisor_i  (w_divisor),
        .rad_pair_i (rad_q[RAD_W-1-2*gi -: 2]),
        .rem_o      (w_rem[gi+1]),
        .bit_o      (w_bit)
      );
      assign w_quot[gi+1] = {w_quot[gi][QUOT_W-2:0], w_bit};
    end
  endgenerate

  // Inexact when any remainder survives or any surplus low result bit is set.
  assign w_sticky = (|w_rem[BitsPerCycle]) | (|(w_quot[BitsPerCycle] & LOW_MASK));

  // Sequencer and datapath registers; kill and reset win over everything else.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      op_q      <= DS_DIV;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      rad_q     <= '0;
      result_q  <= '0;
      sticky_q  <= 1'b0;
    end else if (kill_i) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_BUSY: begin
          rem_q  <= w_rem[BitsPerCycle];
          quot_q <= w_quot[BitsPerCycle];
          rad_q  <= rad_q << (2 * BitsPerCycle);
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_q <= w_quot[BitsPerCycle][QUOT_W-1:EXTRA];
            sticky_q <= w_sticky;
            state_q  <= ST_FINISH;
            ready_q  <= 1'b1;
            done_q   <= 1'b1;
          end
        end
        default: begin
          if (w_start) begin
            state_q   <= ST_BUSY;
            op_q      <= w_start_op;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= CNT_W'(NUM_ITER);
            rem_q     <= (w_start_op == DS_DIV) ? REM_W'(operand_a_i) : '0;
            quot_q    <= '0;
            divisor_q <= operand_b_i;
            rad_q     <= w_rad_init;
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign sticky_o = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_fpnew_divsqrt_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpnew_divsqrt_iter_core
// Description : Self-checking bench: one 24-bit engine for directed protocol
//               cases, two 53-bit engines (1 and 2 bits per cycle) sharing
//               stimulus for latency and random operand checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpnew_divsqrt_iter_core;
  import fpnew_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 24-bit engine
  logic        ds_s = 1'b0, ss_s = 1'b0, eo_s = 1'b0, kill_s = 1'b0;
  logic [23:0] a_s = '0, b_s = '0;
  logic        rdy_s, dn_s, st_s;
  logic [25:0] res_s;
  // 53-bit engines
  logic        ds_l = 1'b0, ss_l = 1'b0, eo_l = 1'b0, kill_l = 1'b0;
  logic [52:0] a_l = '0, b_l = '0;
  logic        rdy_l1, dn_l1, st_l1, rdy_l2, dn_l2, st_l2;
  logic [54:0] res_l1, res_l2;

  fpnew_divsqrt_iter_core #(.MantWidth(24), .BitsPerCycle(1)) u_dut_s (
    .clk_i(clk), .rst_i(rst), .div_start_i(ds_s), .sqrt_start_i(ss_s),
    .operand_a_i(a_s), .operand_b_i(b_s), .exp_odd_i(eo_s), .kill_i(kill_s),
    .ready_o(rdy_s), .done_o(dn_s), .result_o(res_s), .sticky_o(st_s));

  fpnew_divsqrt_iter_core #(.MantWidth(53), .BitsPerCycle(1)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst), .div_start_i(ds_l), .sqrt_start_i(ss_l),
    .operand_a_i(a_l), .operand_b_i(b_l), .exp_odd_i(eo_l), .kill_i(kill_l),
    .ready_o(rdy_l1), .done_o(dn_l1), .result_o(res_l1), .sticky_o(st_l1));

  fpnew_divsqrt_iter_core #(.MantWidth(53), .BitsPerCycle(2)) u_dut_l2 (
    .clk_i(clk), .rst_i(rst), .div_start_i(ds_l), .sqrt_start_i(ss_l),
    .operand_a_i(a_l), .operand_b_i(b_l), .exp_odd_i(eo_l), .kill_i(kill_l),
    .ready_o(rdy_l2), .done_o(dn_l2), .result_o(res_l2), .sticky_o(st_l2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Mathematical reference: {sticky, result}.
  function automatic logic [128:0] ref_calc(input bit is_div, input logic [63:0] a,
                                            input logic [63:0] b, input bit eo, input int w);
    logic [127:0] num, r, cand, y;
    logic         st;
    if (is_div) begin
      num = 128'(a) << (w + 1);
      r   = num / 128'(b);
      st  = (num % 128'(b)) != 0;
    end else begin
      y = (eo ? (128'(a) << 1) : 128'(a)) << (w + 3);
      r = '0;
      for (int i = w + 1; i >= 0; i--) begin
        cand = r | (128'd1 << i);
        if (cand * cand <= y) r = cand;
      end
      st = (r * r) != y;
    end
    return {st, r};
  endfunction

  // start in cycle c -> done in cycle c + latency
  function automatic int lat_of(input int i);
    return (i == 0) ? 27 : ((i == 1) ? 56 : 29);
  endfunction

  logic         o_rdy [3], o_dn [3], o_st [3];
  logic [127:0] o_res [3];
  always_comb begin
    o_rdy[0] = rdy_s;  o_dn[0] = dn_s;  o_st[0] = st_s;  o_res[0] = 128'(res_s);
    o_rdy[1] = rdy_l1; o_dn[1] = dn_l1; o_st[1] = st_l1; o_res[1] = 128'(res_l1);
    o_rdy[2] = rdy_l2; o_dn[2] = dn_l2; o_st[2] = st_l2; o_res[2] = 128'(res_l2);
  end

  bit           m_valid = 1'b0;
  bit           m_busy [3], m_ready [3], m_done [3], m_st [3], p_st [3];
  logic [127:0] m_res [3], p_res [3];
  int           m_done_at [3];

  // Check every instance against the model, then advance the model from the inputs.
  always @(negedge clk) begin : p_compare
    bit           ds, ss, eo, kl;
    logic [63:0]  a, b;
    int           w;
    logic [128:0] r;
    if (m_valid) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("ready%0d", i), 128'(o_rdy[i]), 128'(m_ready[i]));
        chk($sformatf("done%0d", i), 128'(o_dn[i]), 128'(m_done[i]));
        if (m_ready[i]) begin
          chk($sformatf("result%0d", i), o_res[i], m_res[i]);
          chk($sformatf("sticky%0d", i), 128'(o_st[i]), 128'(m_st[i]));
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        ds = ds_s; ss = ss_s; eo = eo_s; kl = kill_s; a = 64'(a_s); b = 64'(b_s); w = 24;
      end else begin
        ds = ds_l; ss = ss_l; eo = eo_l; kl = kill_l; a = 64'(a_l); b = 64'(b_l); w = 53;
      end
      if (rst) begin
        m_busy[i] = 0; m_ready[i] = 1; m_done[i] = 0; m_res[i] = '0; m_st[i] = 0;
      end else if (kl) begin
        m_busy[i] = 0; m_ready[i] = 1; m_done[i] = 0;
      end else if (m_busy[i]) begin
        if (cyc + 1 == m_done_at[i]) begin
          m_busy[i] = 0; m_ready[i] = 1; m_done[i] = 1;
          m_res[i] = p_res[i]; m_st[i] = p_st[i];
        end else begin
          m_ready[i] = 0; m_done[i] = 0;
        end
      end else if (ds || ss) begin
        r = ref_calc(ds, a, b, eo, w);
        p_res[i] = r[127:0]; p_st[i] = r[128];
        m_busy[i] = 1; m_ready[i] = 0; m_done[i] = 0;
        m_done_at[i] = cyc + lat_of(i);
      end else begin
        m_ready[i] = 1; m_done[i] = 0;
      end
    end
    if (rst) m_valid = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_s(input string name, input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (dn_s) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk({name, "_done_seen"}, 128'(seen), 128'd1);
  endtask

  task automatic run_s(input string name, input bit ds, input bit ss, input logic [23:0] a,
                       input logic [23:0] b, input bit eo, input logic [25:0] exp_res,
                       input bit exp_st);
    int s;
    bit seen;
    s = cyc;
    ds_s = ds; ss_s = ss; a_s = a; b_s = b; eo_s = eo;
    tick();
    ds_s = 0; ss_s = 0;
    wait_done_s(name, 40, seen);
    if (seen) chk({name, "_latency"}, 128'(cyc - s), 128'd27);
    chk({name, "_result"}, 128'(res_s), 128'(exp_res));
    chk({name, "_sticky"}, 128'(st_s), 128'(exp_st));
  endtask

  task automatic run_l(input string name, input bit ds, input logic [52:0] a,
                       input logic [52:0] b, input bit eo, input bit pin,
                       input logic [54:0] exp_res, input bit exp_st);
    int s;
    bit seen1, seen2;
    s = cyc;
    ds_l = ds; ss_l = !ds; a_l = a; b_l = b; eo_l = eo;
    tick();
    ds_l = 0; ss_l = 0;
    seen1 = 0; seen2 = 0;
    for (int k = 0; k < 70 && !seen1; k++) begin
      if (dn_l2 && !seen2) begin
        seen2 = 1;
        chk({name, "_lat_bpc2"}, 128'(cyc - s), 128'd29);
        if (pin) chk({name, "_res_bpc2"}, 128'({st_l2, res_l2}), 128'({exp_st, exp_res}));
      end
      if (dn_l1) begin
        seen1 = 1;
        chk({name, "_lat_bpc1"}, 128'(cyc - s), 128'd56);
        if (pin) chk({name, "_res_bpc1"}, 128'({st_l1, res_l1}), 128'({exp_st, exp_res}));
      end
      if (!seen1) tick();
    end
    chk({name, "_seen_bpc1"}, 128'(seen1), 128'd1);
    chk({name, "_seen_bpc2"}, 128'(seen2), 128'd1);
  endtask

  initial begin : p_stim
    int s, n;
    bit seen;
    logic [52:0] ra, rb;

    repeat (3) tick();
    chk("reset_ready", 128'(rdy_s), 128'd1);
    chk("reset_done", 128'(dn_s), 128'd0);
    chk("reset_result", 128'(res_s), 128'd0);
    rst = 1'b0;

    // Pin the reference model on hand-computed values.
    chk("model_div_exact", ref_calc(1, 64'hC00000, 64'h800000, 0, 24), {1'b0, 128'h3000000});
    chk("model_div_inexact", ref_calc(1, 64'h800000, 64'hC00000, 0, 24), {1'b1, 128'h1555555});
    chk("model_sqrt_even", ref_calc(0, 64'h800000, 64'h0, 0, 24), {1'b0, 128'h2000000});
    chk("model_sqrt_odd", ref_calc(0, 64'h800000, 64'h0, 1, 24), {1'b1, 128'h2D413CC});

    // Directed 24-bit cases; consecutive calls start in the FINISH cycle.
    run_s("div_exact", 1, 0, 24'hC00000, 24'h800000, 0, 26'h3000000, 0);
    run_s("div_inexact", 1, 0, 24'h800000, 24'hC00000, 0, 26'h1555555, 1);
    run_s("sqrt_even", 0, 1, 24'h800000, 24'h000000, 0, 26'h2000000, 0);
    run_s("sqrt_odd", 0, 1, 24'h800000, 24'h000000, 1, 26'h2D413CC, 1);
    repeat (3) tick();
    run_s("both_starts", 1, 1, 24'hC00000, 24'h800000, 0, 26'h3000000, 0);

    // Starts while busy are ignored.
    s = cyc;
    ds_s = 1; a_s = 24'hC00000; b_s = 24'h800000; eo_s = 0;
    tick();
    ds_s = 0;
    repeat (4) tick();
    ds_s = 1; ss_s = 1; a_s = 24'h800000; b_s = 24'hC00000; eo_s = 1;
    tick();
    ds_s = 0; ss_s = 0;
    wait_done_s("busy_start", 40, seen);
    if (seen) chk("busy_start_latency", 128'(cyc - s), 128'd27);
    chk("busy_start_result", 128'(res_s), 128'h3000000);
    chk("busy_start_sticky", 128'(st_s), 128'd0);

    // Kill in BUSY cycle 10 together with a new start.
    repeat (2) tick();
    s = cyc;
    ds_s = 1; a_s = 24'h800000; b_s = 24'hC00000;
    tick();
    ds_s = 0;
    while (cyc < s + 10) tick();
    kill_s = 1; ds_s = 1; a_s = 24'hC00000; b_s = 24'h800000;
    tick();
    kill_s = 0; ds_s = 0;
    chk("kill_ready", 128'(rdy_s), 128'd1);
    chk("kill_done", 128'(dn_s), 128'd0);
    n = 0;
    repeat (40) begin
      if (dn_s) n++;
      tick();
    end
    chk("kill_no_done", 128'(n), 128'd0);
    chk("kill_result_kept", 128'(res_s), 128'h3000000);

    // Reset in the middle of an operation.
    ss_s = 1; a_s = 24'h800000; eo_s = 1;
    tick();
    ss_s = 0;
    repeat (12) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_ready", 128'(rdy_s), 128'd1);
    chk("midrst_done", 128'(dn_s), 128'd0);
    chk("midrst_result", 128'(res_s), 128'd0);
    chk("midrst_sticky", 128'(st_s), 128'd0);
    n = 0;
    repeat (30) begin
      if (dn_s) n++;
      tick();
    end
    chk("midrst_no_done", 128'(n), 128'd0);
    run_s("after_rst", 1, 0, 24'h800000, 24'hC00000, 0, 26'h1555555, 1);

    // 53-bit engines: pinned value, then random legal operands.
    run_l("w53_div", 1, 53'h18_0000_0000_0000, 53'h10_0000_0000_0000, 0, 1,
          55'h60_0000_0000_0000, 0);
    run_l("w53_sqrt", 0, 53'h10_0000_0000_0000, 53'h0, 0, 1, 55'h40_0000_0000_0000, 0);
    for (int k = 0; k < 24; k++) begin
      ra = {1'b1, 20'($urandom), 32'($urandom)};
      rb = {1'b1, 20'($urandom), 32'($urandom)};
      run_l($sformatf("w53_rand%0d", k), (k % 2) == 0, ra, rb, 1'($urandom), 0, '0, 0);
    end
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : p_watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
